rv_multicycle_ctrl: RTL

- Multicycle RV32I controller FSM that sequences one instruction over 3-5+ states, sharing one ALU and one unified memory.
- Sits beside the multicycle datapath and drives its mux selects and write enables from the registered instruction fields and the ALU zero flag.
- Generalised over the single-cycle control unit: parametrised ALU-control width, configurable memory wait states, bne support, and an illegal-instruction trap.

---
 rtl/rv_multicycle_ctrl.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv_multicycle_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rv_multicycle_ctrl
//
// Control FSM for a multicycle RV32I datapath with one shared ALU and one
// unified memory. Each instruction is sequenced over several states. The
// controller drives the datapath mux selects and write enables from the
// registered instruction fields and the ALU zero flag.
//
// Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, bne, jal.
// Any other opcode, an ALU funct3 that the configured ALU cannot execute, or
// a branch funct3 other than beq/bne parks the FSM in TRAP until reset.
//
// Parameters
//   ALUCTRL_W  ALUControl width, 3 or 4. Width 4 adds xor/sll/srl/sra.
//   MEM_LAT    extra wait cycles in FETCH and MEMREAD before memory data is
//              valid (0..15).
//
// Optional build macro
//   MC_CTRL_RETIRE_CNT_EN  adds a 32-bit 'retired' output counting completed
//                          instructions (one count per instr_done cycle).
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   op, funct3,      instruction fields from the instruction register
//   funct7b5
//   zero             ALU zero flag
//   PCWrite          PC register enable
//   AdrSrc           memory address select (0 = PC, 1 = ALUOut)
//   MemWrite         memory write enable
//   IRWrite          instruction register / OldPC enable
//   ResultSrc        00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA          00 = PC, 01 = OldPC, 10 = rs1
//   ALUSrcB          00 = rs2, 01 = Imm, 10 = constant 4
//   ImmSrc           00 = I, 01 = S, 10 = B, 11 = J (from op only)
//   ALUControl       ALU operation code
//   RegWrite         register file write enable
//   instr_done       one-cycle pulse in the last state of each instruction
//   illegal          high while in TRAP
//   retired          (optional) retired-instruction counter
// -----------------------------------------------------------------------------
module rv_multicycle_ctrl #(
    parameter int ALUCTRL_W = 3,
    parameter int MEM_LAT   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 RegWrite,
    output logic                 instr_done,
    output logic                 illegal
`ifdef MC_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]          retired
`endif
);

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0000);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0001);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0010);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0011);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4'b0101);
    localparam logic [ALUCTRL_W-1:0] ALU_XOR = ALUCTRL_W'(4'b0100);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL = ALUCTRL_W'(4'b0110);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL = ALUCTRL_W'(4'b0111);
    localparam logic [ALUCTRL_W-1:0] ALU_SRA = ALUCTRL_W'(4'b1111);

    // Wait-state target for the FETCH / MEMREAD counter.
    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           wait_done;

    // Ungated write enables; the reset gating is applied at the ports.
    logic           pcw_raw, memw_raw, irw_raw, regw_raw;

    logic [ALUCTRL_W-1:0] alu_dec;
    logic                 alu_ok;

    assign wait_done = (cnt_q == LAT);

    // ALU operation for EXECUTER/EXECUTEI, plus whether the configured ALU
    // can execute this funct3 at all (unsupported codes trap from DECODE).
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        alu_dec = ALU_ADD;
        alu_ok  = 1'b1;
        case (funct3)
            3'b000: alu_dec = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010: alu_dec = ALU_SLT;
            3'b110: alu_dec = ALU_OR;
            3'b111: alu_dec = ALU_AND;
            3'b100: begin
                if (ALUCTRL_W == 4) alu_dec = ALU_XOR;
                else                alu_ok  = 1'b0;
            end
            3'b001: begin
                if (ALUCTRL_W == 4) alu_dec = ALU_SLL;
                else                alu_ok  = 1'b0;
            end
            3'b101: begin
                if (ALUCTRL_W == 4) alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
                else                alu_ok  = 1'b0;
            end
            default: alu_ok = 1'b0;   // funct3 011 (sltu) is not supported
        endcase
    end

    // Immediate format depends on the opcode only, independent of state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:     ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        pcw_raw    = 1'b0;
        memw_raw   = 1'b0;
        irw_raw    = 1'b0;
        regw_raw   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC + 4 computed here; IR and PC load only once memory is ready.
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (wait_done) begin
                    pcw_raw = 1'b1;
                    irw_raw = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DECODE: begin
                // Branch target OldPC + Imm lands in ALUOut for BRANCH.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = alu_ok ? S_EXECUTER : S_TRAP;
                    OP_ITYPE:     state_d = alu_ok ? S_EXECUTEI : S_TRAP;
                    OP_BRANCH:    state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (wait_done) state_d = S_MEMWB;
                else           cnt_d   = cnt_q + 4'd1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                regw_raw   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                memw_raw   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec;
                state_d    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                regw_raw   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                // funct3[0] distinguishes bne (take on not-equal) from beq.
                pcw_raw    = funct3[0] ? ~zero : zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // OldPC + 4 is the link value; PC takes the jump target from ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pcw_raw = 1'b1;
                state_d = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are suppressed for the whole reset cycle so an abandoned
    // instruction can never commit architectural state.
    assign PCWrite  = pcw_raw  & ~reset;
    assign IRWrite  = irw_raw  & ~reset;
    assign MemWrite = memw_raw & ~reset;
    assign RegWrite = regw_raw & ~reset;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MC_CTRL_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    // Wraps naturally at 2^32; TRAP never pulses instr_done so the count holds.
    always_comb begin
        retired_d = retired_q;
        if (instr_done) retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) retired_q <= '0;
        else       retired_q <= retired_d;
    end

    assign retired = retired_q;
`endif

endmodule
